// File: rtl/mac_tile_multilane_pkg.sv
// Shared definitions for the multilane MAC tile: instruction encodings
// and the position of the dataflow mode bit inside an instruction.
package mac_tile_multilane_pkg;

  // Weight-stationary instructions (mode bit clear)
  localparam logic [2:0] INST_W_IDLE  = 3'b000;
  localparam logic [2:0] INST_W_LOAD  = 3'b001;
  localparam logic [2:0] INST_W_EXEC  = 3'b010;
  localparam logic [2:0] INST_W_SWAP  = 3'b011;

  // Output-stationary instructions (mode bit set)
  localparam logic [2:0] INST_IDLE    = 3'b100;
  localparam logic [2:0] INST_O_SHIFT = 3'b101;
  localparam logic [2:0] INST_O_EXEC  = 3'b110;
  localparam logic [2:0] INST_RESET   = 3'b111;

  // Bit 2 selects the dataflow: 0 = weight-stationary, 1 = output-stationary
  localparam int MODE_BIT = 2;

endpackage

// File: rtl/mac_tile_multilane_if.sv
// Neighbour-facing bus of one PE tile: instruction and activations enter
// from the west, psums/operands from the north; registered copies leave
// east and results leave south.
interface mac_tile_multilane_if #(
  parameter int LANES   = 2,
  parameter int bw      = 4,
  parameter int psum_bw = 16
);

  logic [2:0]               inst_w;
  logic [LANES*bw-1:0]      in_w;
  logic [LANES*psum_bw-1:0] in_n;
  logic [2:0]               inst_e;
  logic [LANES*bw-1:0]      out_e;
  logic [LANES*psum_bw-1:0] out_s;

  // Upstream side: drives the tile inputs, observes its outputs
  modport master (
    output inst_w, in_w, in_n,
    input  inst_e, out_e, out_s
  );

  // Tile side
  modport slave (
    input  inst_w, in_w, in_n,
    output inst_e, out_e, out_s
  );

endinterface

// File: rtl/mac_tile_multilane_mac_lane.sv
// One lane of arithmetic: sum = a*b + c with signed/unsigned extension and
// optional saturation to the psum range. Purely combinational.
module mac_lane #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter bit SIGNED  = 1'b0,
  parameter bit SAT     = 1'b0
) (
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  input  logic [psum_bw-1:0] c,
  output logic [psum_bw-1:0] sum
);

  localparam int PW = 2 * bw;
  // Two guard bits so the true sum never overflows before clamping
  localparam int EW = psum_bw + 2;

  logic          a_sgn_s, b_sgn_s, p_sgn_s, c_sgn_s;
  logic [PW-1:0] a_ext_s, b_ext_s, prod_s;
  logic [EW-1:0] prod_ext_s, c_ext_s, sum_ext_s;

  // Extend operands, multiply, add in a widened domain, then clamp or wrap
  always_comb begin
    a_sgn_s    = SIGNED ? a[bw-1] : 1'b0;
    b_sgn_s    = SIGNED ? b[bw-1] : 1'b0;
    // Operands pre-extended to the product width, so the low PW bits of the
    // product are exact in both signed and unsigned modes
    a_ext_s    = {{bw{a_sgn_s}}, a};
    b_ext_s    = {{bw{b_sgn_s}}, b};
    prod_s     = a_ext_s * b_ext_s;
    p_sgn_s    = SIGNED ? prod_s[PW-1] : 1'b0;
    c_sgn_s    = SIGNED ? c[psum_bw-1] : 1'b0;
    prod_ext_s = {{(EW-PW){p_sgn_s}}, prod_s};
    c_ext_s    = {{2{c_sgn_s}}, c};
    sum_ext_s  = prod_ext_s + c_ext_s;
    sum        = sum_ext_s[psum_bw-1:0];
    if (SAT) begin
      if (SIGNED) begin
        // In range only when the two guard bits match the psum sign bit
        if (sum_ext_s[EW-1:psum_bw-1] != {3{sum_ext_s[EW-1]}}) begin
          sum = sum_ext_s[EW-1] ? {1'b1, {(psum_bw-1){1'b0}}}
                                : {1'b0, {(psum_bw-1){1'b1}}};
        end else begin
          sum = sum_ext_s[psum_bw-1:0];
        end
      end else begin
        if (sum_ext_s[psum_bw]) begin
          sum = {psum_bw{1'b1}};
        end else begin
          sum = sum_ext_s[psum_bw-1:0];
        end
      end
    end else begin
      sum = sum_ext_s[psum_bw-1:0];
    end
  end

endmodule

// File: rtl/mac_tile_multilane.sv
// Reconfigurable PE tile: LANES MAC lanes sharing one instruction stream,
// weight-stationary with a double-buffered weight, or output-stationary
// with in-place accumulation and a psum shift chain.
module mac_tile_multilane
  import mac_tile_multilane_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter bit SIGNED  = 1'b0,
  parameter bit SAT     = 1'b0
) (
  input logic                  clk,
  input logic                  reset_n,
  mac_tile_multilane_if.slave  bus
);

  localparam int AW = LANES * bw;
  localparam int PW = LANES * psum_bw;

  logic [2:0]    inst_r;
  logic [AW-1:0] a_r, w_act_r, w_shd_r, b_r;
  logic [PW-1:0] c_r, c_pipe_r;
  logic          shd_empty_r, shift_first_r;

  logic          clr_s;
  logic [PW-1:0] ws_sum_s, os_sum_s, b_ext_s, out_s_s;

  // The RESET instruction clears the same state as the reset pin
  assign clr_s = !reset_n || (bus.inst_w == INST_RESET);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.bw(bw), .psum_bw(psum_bw), .SIGNED(SIGNED), .SAT(SAT)) u_ws_mac (
      .a   (a_r[i*bw +: bw]),
      .b   (w_act_r[i*bw +: bw]),
      .c   (c_r[i*psum_bw +: psum_bw]),
      .sum (ws_sum_s[i*psum_bw +: psum_bw])
    );
    mac_lane #(.bw(bw), .psum_bw(psum_bw), .SIGNED(SIGNED), .SAT(SAT)) u_os_mac (
      .a   (a_r[i*bw +: bw]),
      .b   (b_r[i*bw +: bw]),
      .c   (c_r[i*psum_bw +: psum_bw]),
      .sum (os_sum_s[i*psum_bw +: psum_bw])
    );
    assign b_ext_s[i*psum_bw +: psum_bw] =
      {{(psum_bw-bw){SIGNED & b_r[i*bw+bw-1]}}, b_r[i*bw +: bw]};
  end

  // Instruction forwarding and the shadow-buffer / first-shift flags
  always_ff @(posedge clk) begin
    if (clr_s) begin
      inst_r        <= reset_n ? INST_RESET : INST_W_IDLE;
      shd_empty_r   <= 1'b1;
      shift_first_r <= 1'b1;
    end else begin
      inst_r[2:1] <= bus.inst_w[2:1];
      // Hold back the low bit in WS mode until this tile owns its weight,
      // so a W_LOAD only ripples east once the shadow buffer is filled
      inst_r[0]   <= (!bus.inst_w[MODE_BIT] && shd_empty_r) ? 1'b0 : bus.inst_w[0];
      if (bus.inst_w == INST_W_LOAD) begin
        shd_empty_r <= 1'b0;
      end else if (bus.inst_w == INST_W_SWAP) begin
        shd_empty_r <= 1'b1;
      end
      if (bus.inst_w == INST_O_SHIFT) begin
        shift_first_r <= 1'b0;
      end
    end
  end

  // Lane datapath registers: operands, weights and partial sums
  always_ff @(posedge clk) begin
    if (clr_s) begin
      a_r      <= '0;
      w_act_r  <= '0;
      w_shd_r  <= '0;
      b_r      <= '0;
      c_r      <= '0;
      c_pipe_r <= '0;
    end else begin
      if ((bus.inst_w == INST_W_LOAD) || (bus.inst_w == INST_W_EXEC) ||
          (bus.inst_w == INST_O_EXEC)) begin
        a_r <= bus.in_w;
      end
      if ((bus.inst_w == INST_W_LOAD) && shd_empty_r) begin
        w_shd_r <= bus.in_w;
      end
      // A swap on an empty shadow deliberately reloads the stale weight
      if (bus.inst_w == INST_W_SWAP) begin
        w_act_r <= w_shd_r;
      end
      if (bus.inst_w == INST_O_EXEC) begin
        for (int i = 0; i < LANES; i++) begin
          b_r[i*bw +: bw] <= bus.in_n[i*psum_bw +: bw];
        end
      end
      if (bus.inst_w == INST_O_SHIFT) begin
        c_pipe_r <= bus.in_n;
      end
      // The final accumulate of an O_EXEC burst wins over a shift arriving
      // in the same cycle, so the finished sum is visible while shifting
      if (bus.inst_w == INST_W_EXEC) begin
        c_r <= bus.in_n;
      end else if (inst_r == INST_O_EXEC) begin
        c_r <= os_sum_s;
      end else if ((bus.inst_w == INST_O_SHIFT) && !shift_first_r) begin
        c_r <= c_pipe_r;
      end
    end
  end

  // South output: WS MAC result, OS shifted psum, or OS operand passthrough
  always_comb begin
    out_s_s = '0;
    if (!inst_r[MODE_BIT]) begin
      out_s_s = ws_sum_s;
    end else if (inst_r == INST_O_SHIFT) begin
      out_s_s = c_r;
    end else begin
      out_s_s = b_ext_s;
    end
  end

  assign bus.inst_e = inst_r;
  assign bus.out_e  = a_r;
  assign bus.out_s  = out_s_s;

endmodule

// File: tb/tb_mac_tile_multilane.sv
// Directed bench for mac_tile_multilane: an unsigned/wrapping tile driven
// from a vector table, plus a signed/saturating tile driven by hand.
module tb_mac_tile_multilane;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mac_tile_multilane_if #(.LANES(2), .bw(4), .psum_bw(16)) bus_u ();
  mac_tile_multilane_if #(.LANES(2), .bw(4), .psum_bw(16)) bus_s ();

  mac_tile_multilane #(.LANES(2), .bw(4), .psum_bw(16), .SIGNED(1'b0), .SAT(1'b0)) u_dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_u)
  );

  mac_tile_multilane #(.LANES(2), .bw(4), .psum_bw(16), .SIGNED(1'b1), .SAT(1'b1)) u_dut_s (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_s)
  );

  typedef struct {
    logic        rst_n;
    logic [2:0]  inst;
    logic [7:0]  in_w;
    logic [31:0] in_n;
    logic [2:0]  exp_ie;
    logic [7:0]  exp_oe;
    logic [31:0] exp_os;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] inst, input logic [7:0] in_w,
                     input logic [31:0] in_n, input logic [2:0] ie,
                     input logic [7:0] oe, input logic [31:0] os);
    vec_t v;
    v.rst_n = r; v.inst = inst; v.in_w = in_w; v.in_n = in_n;
    v.exp_ie = ie; v.exp_oe = oe; v.exp_os = os;
    vecs.push_back(v);
  endtask

  // One cycle on the signed tile: drive at negedge, check at next negedge
  task automatic step_s(input string name, input logic [2:0] inst, input logic [7:0] in_w,
                        input logic [31:0] in_n, input logic [2:0] ie, input logic [31:0] os);
    bus_s.inst_w = inst;
    bus_s.in_w   = in_w;
    bus_s.in_n   = in_n;
    @(negedge clk);
    chk({name, " inst_e"}, {29'd0, bus_s.inst_e}, {29'd0, ie});
    chk({name, " out_s"}, bus_s.out_s, os);
  endtask

  initial begin
    // WS double buffer: load {3,2}, swap, exec a={5,7} c={10,1}
    add(1'b1, 3'b001, 8'h32, 32'h0000_0000, 3'b000, 8'h32, 32'h0000_0000);
    add(1'b1, 3'b011, 8'hFF, 32'h0000_0000, 3'b011, 8'h32, 32'h0009_0004);
    add(1'b1, 3'b010, 8'h57, 32'h000A_0001, 3'b010, 8'h57, 32'h0019_000F);
    add(1'b1, 3'b000, 8'h00, 32'h0000_0000, 3'b000, 8'h57, 32'h0019_000F);
    // Load gating: {2,2} captured, {9,9} only passes through
    add(1'b1, 3'b001, 8'h22, 32'h0000_0000, 3'b000, 8'h22, 32'h0010_0005);
    add(1'b1, 3'b001, 8'h99, 32'h0000_0000, 3'b001, 8'h99, 32'h0025_0013);
    add(1'b1, 3'b011, 8'h00, 32'h0000_0000, 3'b011, 8'h99, 32'h001C_0013);
    add(1'b1, 3'b010, 8'h11, 32'h0000_0000, 3'b010, 8'h11, 32'h0002_0002);
    // OS accumulate: 3x O_EXEC a={1,2} b={3,4}, then two shifts
    add(1'b1, 3'b110, 8'h12, 32'h0003_0004, 3'b110, 8'h12, 32'h0003_0004);
    add(1'b1, 3'b110, 8'h12, 32'h0003_0004, 3'b110, 8'h12, 32'h0003_0004);
    add(1'b1, 3'b110, 8'h12, 32'h0003_0004, 3'b110, 8'h12, 32'h0003_0004);
    add(1'b1, 3'b101, 8'h00, 32'h004D_0058, 3'b101, 8'h12, 32'h0009_0018);
    add(1'b1, 3'b101, 8'h00, 32'h004D_0058, 3'b101, 8'h12, 32'h004D_0058);
    // RESET instruction in the middle of O_EXEC
    add(1'b1, 3'b110, 8'h11, 32'h0001_0001, 3'b110, 8'h11, 32'h0001_0001);
    add(1'b1, 3'b111, 8'hAB, 32'h1234_5678, 3'b111, 8'h00, 32'h0000_0000);
    add(1'b1, 3'b101, 8'h00, 32'h0005_0006, 3'b101, 8'h00, 32'h0000_0000);
    add(1'b1, 3'b101, 8'h00, 32'h0000_0000, 3'b101, 8'h00, 32'h0005_0006);
    // reset_n during W_LOAD empties the shadow again
    add(1'b1, 3'b001, 8'h44, 32'h0000_0000, 3'b000, 8'h44, 32'h0005_0006);
    add(1'b0, 3'b001, 8'h44, 32'h0000_0000, 3'b000, 8'h00, 32'h0000_0000);
    add(1'b1, 3'b001, 8'h66, 32'h0000_0000, 3'b000, 8'h66, 32'h0000_0000);
    add(1'b1, 3'b011, 8'h00, 32'h0000_0000, 3'b011, 8'h66, 32'h0024_0024);
    // Unsigned wrap and large products
    add(1'b1, 3'b010, 8'h11, 32'h0064_FFFF, 3'b010, 8'h11, 32'h006A_0005);
    add(1'b1, 3'b010, 8'hF8, 32'h7FF0_7FF0, 3'b010, 8'hF8, 32'h804A_8020);

    bus_s.inst_w = 3'b000;
    bus_s.in_w   = 8'h00;
    bus_s.in_n   = 32'h0;

    // Reset held two cycles with random inputs
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_u.inst_w = 3'($urandom);
      bus_u.in_w   = 8'($urandom);
      bus_u.in_n   = $urandom;
      @(negedge clk);
    end
    chk("reset inst_e", {29'd0, bus_u.inst_e}, 32'd0);
    chk("reset out_e", {24'd0, bus_u.out_e}, 32'd0);
    chk("reset out_s", bus_u.out_s, 32'd0);
    chk("reset signed out_s", bus_s.out_s, 32'd0);

    // Table-driven run on the unsigned tile
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n        = vecs[i].rst_n;
      bus_u.inst_w = vecs[i].inst;
      bus_u.in_w   = vecs[i].in_w;
      bus_u.in_n   = vecs[i].in_n;
      @(negedge clk);
      chk($sformatf("v%0d inst_e", i), {29'd0, bus_u.inst_e}, {29'd0, vecs[i].exp_ie});
      chk($sformatf("v%0d out_e", i), {24'd0, bus_u.out_e}, {24'd0, vecs[i].exp_oe});
      chk($sformatf("v%0d out_s", i), bus_u.out_s, vecs[i].exp_os);
    end

    // Signed saturating tile
    rst_n        = 1'b1;
    bus_u.inst_w = 3'b000;
    bus_u.in_w   = 8'h00;
    bus_u.in_n   = 32'h0;
    step_s("s_load", 3'b001, 8'h77, 32'h0000_0000, 3'b000, 32'h0000_0000);
    step_s("s_swap", 3'b011, 8'h00, 32'h0000_0000, 3'b011, 32'h0031_0031);
    step_s("s_sat_pos", 3'b010, 8'h78, 32'h7FF0_7FF0, 3'b010, 32'h7FFF_7FB8);
    step_s("s_sat_neg", 3'b010, 8'h88, 32'h8000_FFF0, 3'b010, 32'h8000_FFB8);
    step_s("s_b_sext", 3'b110, 8'h00, 32'h0008_0007, 3'b110, 32'hFFF8_0007);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
